sp1_hmem_arb: RTL and testbench

- Two-requester arbiter in front of the dual-word heap memory port (sp1_hmem_heap), at stage <5>.
- Requester A is the evaluator; requester B is the allocator/GC copy engine.
- Arbitration is round-robin. A lock lets either side hold the port for back-to-back accesses, bounded by a starvation limit.
- Read data is returned at stage <6>, with a valid strobe routed to the requester that issued the read.

---
 rtl/sp1_hmem_arb.sv | 224 ++++++++++++++++++++++
 tb/tb_sp1_hmem_arb.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp1_hmem_arb.sv
// sp1_hmem_arb: two-requester round-robin arbiter in front of the dual-word
// heap memory port. Requester A is the evaluator and requester B is the
// allocator/GC copy engine. Either side may lock the port for back-to-back
// accesses. A starvation counter bounds how long the other side can be shut out.
// Read data comes back one cycle after the grant. A valid strobe goes to
// whichever requester issued the read.

`ifndef SP1_WORD_WIDTH
`define SP1_WORD_WIDTH 32
`endif

module sp1_hmem_arb #(
    parameter int DW          = `SP1_WORD_WIDTH,
    parameter int STARVE_MAX  = 8,
    parameter int STARVE_BITS = 4
) (
    input  logic          clk,
    input  logic          rst,          // asynchronous, active-low

    // requester A (evaluator)
    input  logic          h5_a_req,
    output logic          h5_a_ack,
    input  logic          h5_a_type,    // 1: write, 0: read
    input  logic          h5_a_sz,      // 1: double, 0: single
    input  logic          h5_a_lock,
    input  logic [DW-1:0] h5_a_adrs,
    input  logic [DW-1:0] h5_a_wr_dt0,
    input  logic [DW-1:0] h5_a_wr_dt1,
    output logic          h6_a_rd_vld,

    // requester B (allocator / GC copy engine)
    input  logic          h5_b_req,
    output logic          h5_b_ack,
    input  logic          h5_b_type,
    input  logic          h5_b_sz,
    input  logic          h5_b_lock,
    input  logic [DW-1:0] h5_b_adrs,
    input  logic [DW-1:0] h5_b_wr_dt0,
    input  logic [DW-1:0] h5_b_wr_dt1,
    output logic          h6_b_rd_vld,

    // heap port
    output logic          h5_hmem_acs_en,
    output logic          h5_hmem_acs_type,
    output logic          h5_hmem_acs_sz,
    output logic [DW-1:0] h5_hmem_acs_adrs,
    output logic [DW-1:0] h5_hmem_wr_dt0,
    output logic [DW-1:0] h5_hmem_wr_dt1,
    input  logic [DW-1:0] h6_hmem_rd_dt0,
    input  logic [DW-1:0] h6_hmem_rd_dt1,

    // shared read data
    output logic [DW-1:0] h6_rd_dt0,
    output logic [DW-1:0] h6_rd_dt1
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK_A = 2'd1,
        ST_LOCK_B = 2'd2
    } state_t;

    // Last-grant encoding: the side other than lg wins a tie.
    localparam logic LG_A = 1'b0;
    localparam logic LG_B = 1'b1;

    localparam logic [STARVE_BITS-1:0] SC_LIMIT = STARVE_BITS'(STARVE_MAX);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_lg;
    logic                   w_lg_nxt;
    logic [STARVE_BITS-1:0] r_sc;
    logic [STARVE_BITS-1:0] w_sc_nxt;
    logic                   w_a_ack;
    logic                   w_b_ack;
    logic                   w_a_rd;
    logic                   w_b_rd;

    // Grant decision and next-state logic for the lock/round-robin FSM.
    // NOTE: every variable gets a default at the top so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_a_ack     = 1'b0;
        w_b_ack     = 1'b0;
        w_state_nxt = r_state;
        w_lg_nxt    = r_lg;
        w_sc_nxt    = r_sc;

        case (r_state)
            ST_IDLE: begin
                w_sc_nxt = '0;
                if (h5_a_req && (!h5_b_req || r_lg == LG_B)) begin
                    w_a_ack = 1'b1;
                end else if (h5_b_req) begin
                    w_b_ack = 1'b1;
                end

                if (w_a_ack) begin
                    w_lg_nxt = LG_A;
                    if (h5_a_lock) begin
                        w_state_nxt = ST_LOCK_A;
                    end
                end else if (w_b_ack) begin
                    w_lg_nxt = LG_B;
                    if (h5_b_lock) begin
                        w_state_nxt = ST_LOCK_B;
                    end
                end
            end

            ST_LOCK_A: begin
                // Only the owner may be granted. A grant in the cycle the
                // lock breaks still completes.
                w_a_ack = h5_a_req;
                if (w_a_ack) begin
                    w_lg_nxt = LG_A;
                end

                if (r_sc == SC_LIMIT) begin
                    // The starvation break takes priority over a renewed lock.
                    w_state_nxt = ST_IDLE;
                    w_lg_nxt    = LG_A;
                    w_sc_nxt    = '0;
                end else if (w_a_ack && !h5_a_lock) begin
                    w_state_nxt = ST_IDLE;
                    w_sc_nxt    = '0;
                end else if (h5_b_req) begin
                    w_sc_nxt = r_sc + 1'b1;
                end
            end

            ST_LOCK_B: begin
                w_b_ack = h5_b_req;
                if (w_b_ack) begin
                    w_lg_nxt = LG_B;
                end

                if (r_sc == SC_LIMIT) begin
                    w_state_nxt = ST_IDLE;
                    w_lg_nxt    = LG_B;
                    w_sc_nxt    = '0;
                end else if (w_b_ack && !h5_b_lock) begin
                    w_state_nxt = ST_IDLE;
                    w_sc_nxt    = '0;
                end else if (h5_a_req) begin
                    w_sc_nxt = r_sc + 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_sc_nxt    = '0;
            end
        endcase
    end

    // FSM state, last-grant pointer and starvation counter.
    // NOTE: state registers use non-blocking assignments so that every flop
    // samples values from before the edge, whatever order the blocks run in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_lg    <= LG_B;
            r_sc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lg    <= w_lg_nxt;
            r_sc    <= w_sc_nxt;
        end
    end

    assign h5_a_ack = w_a_ack;
    assign h5_b_ack = w_b_ack;

    // Heap access fields come from the winner. All fields are zero when
    // there is no grant.
    always_comb begin
        h5_hmem_acs_en   = w_a_ack | w_b_ack;
        h5_hmem_acs_type = 1'b0;
        h5_hmem_acs_sz   = 1'b0;
        h5_hmem_acs_adrs = '0;
        h5_hmem_wr_dt0   = '0;
        h5_hmem_wr_dt1   = '0;
        if (w_a_ack) begin
            h5_hmem_acs_type = h5_a_type;
            h5_hmem_acs_sz   = h5_a_sz;
            h5_hmem_acs_adrs = h5_a_adrs;
            h5_hmem_wr_dt0   = h5_a_wr_dt0;
            h5_hmem_wr_dt1   = h5_a_wr_dt1;
        end else if (w_b_ack) begin
            h5_hmem_acs_type = h5_b_type;
            h5_hmem_acs_sz   = h5_b_sz;
            h5_hmem_acs_adrs = h5_b_adrs;
            h5_hmem_wr_dt0   = h5_b_wr_dt0;
            h5_hmem_wr_dt1   = h5_b_wr_dt1;
        end
    end

    assign w_a_rd = w_a_ack & ~h5_a_type;
    assign w_b_rd = w_b_ack & ~h5_b_type;

    // Read-return strobes: one cycle after a granted read, to its issuer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h6_a_rd_vld <= 1'b0;
            h6_b_rd_vld <= 1'b0;
        end else begin
            h6_a_rd_vld <= w_a_rd;
            h6_b_rd_vld <= w_b_rd;
        end
    end

    // The heap already aligns its read data with the return cycle.
    assign h6_rd_dt0 = h6_hmem_rd_dt0;
    assign h6_rd_dt1 = h6_hmem_rd_dt1;

    // Grant sanity: at most one winner per cycle, and never a grant without a request.
    a_one_ack : assert property (@(posedge clk) disable iff (!rst)
        !(h5_a_ack && h5_b_ack));
    a_ack_req : assert property (@(posedge clk) disable iff (!rst)
        (!h5_a_ack || h5_a_req) && (!h5_b_ack || h5_b_req));

endmodule

// File: tb/tb_sp1_hmem_arb.sv
// Testbench for sp1_hmem_arb. It includes a small behavioural heap that
// returns read data one cycle after the access. A scoreboard queue holds
// the read returns the bench expects to see.
module tb_sp1_hmem_arb;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          h5_a_req, h5_a_ack, h5_a_type, h5_a_sz, h5_a_lock, h6_a_rd_vld;
    logic [DW-1:0] h5_a_adrs, h5_a_wr_dt0, h5_a_wr_dt1;
    logic          h5_b_req, h5_b_ack, h5_b_type, h5_b_sz, h5_b_lock, h6_b_rd_vld;
    logic [DW-1:0] h5_b_adrs, h5_b_wr_dt0, h5_b_wr_dt1;
    logic          h5_hmem_acs_en, h5_hmem_acs_type, h5_hmem_acs_sz;
    logic [DW-1:0] h5_hmem_acs_adrs, h5_hmem_wr_dt0, h5_hmem_wr_dt1;
    logic [DW-1:0] h6_hmem_rd_dt0 = '0;
    logic [DW-1:0] h6_hmem_rd_dt1 = '0;
    logic [DW-1:0] h6_rd_dt0, h6_rd_dt1;

    always #5 clk = ~clk;

    sp1_hmem_arb #(.DW(DW), .STARVE_MAX(8), .STARVE_BITS(4)) dut (
        .clk(clk), .rst(rst),
        .h5_a_req(h5_a_req), .h5_a_ack(h5_a_ack), .h5_a_type(h5_a_type),
        .h5_a_sz(h5_a_sz), .h5_a_lock(h5_a_lock), .h5_a_adrs(h5_a_adrs),
        .h5_a_wr_dt0(h5_a_wr_dt0), .h5_a_wr_dt1(h5_a_wr_dt1), .h6_a_rd_vld(h6_a_rd_vld),
        .h5_b_req(h5_b_req), .h5_b_ack(h5_b_ack), .h5_b_type(h5_b_type),
        .h5_b_sz(h5_b_sz), .h5_b_lock(h5_b_lock), .h5_b_adrs(h5_b_adrs),
        .h5_b_wr_dt0(h5_b_wr_dt0), .h5_b_wr_dt1(h5_b_wr_dt1), .h6_b_rd_vld(h6_b_rd_vld),
        .h5_hmem_acs_en(h5_hmem_acs_en), .h5_hmem_acs_type(h5_hmem_acs_type),
        .h5_hmem_acs_sz(h5_hmem_acs_sz), .h5_hmem_acs_adrs(h5_hmem_acs_adrs),
        .h5_hmem_wr_dt0(h5_hmem_wr_dt0), .h5_hmem_wr_dt1(h5_hmem_wr_dt1),
        .h6_hmem_rd_dt0(h6_hmem_rd_dt0), .h6_hmem_rd_dt1(h6_hmem_rd_dt1),
        .h6_rd_dt0(h6_rd_dt0), .h6_rd_dt1(h6_rd_dt1)
    );

    // ---------------- heap model ----------------
    bit [DW-1:0] heap    [0:1023];
    bit          written [0:1023];

    // Locations that were never written read back as a fixed address pattern.
    function automatic logic [DW-1:0] pat(input logic [DW-1:0] a);
        return a ^ 32'h5a5a_0000;
    endfunction

    function automatic logic [DW-1:0] heap_rd(input logic [DW-1:0] a);
        return written[a[9:0]] ? heap[a[9:0]] : pat(a);
    endfunction

    always @(posedge clk) begin
        if (h5_hmem_acs_en) begin
            if (h5_hmem_acs_type) begin
                heap[h5_hmem_acs_adrs[9:0]]    <= h5_hmem_wr_dt0;
                written[h5_hmem_acs_adrs[9:0]] <= 1'b1;
                if (h5_hmem_acs_sz) begin
                    heap[h5_hmem_acs_adrs[9:0] + 10'd1]    <= h5_hmem_wr_dt1;
                    written[h5_hmem_acs_adrs[9:0] + 10'd1] <= 1'b1;
                end
            end else begin
                h6_hmem_rd_dt0 <= heap_rd(h5_hmem_acs_adrs);
                h6_hmem_rd_dt1 <= heap_rd(h5_hmem_acs_adrs + 1);
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic          who;   // 0: A, 1: B
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Each read-valid strobe pops one expected return.
    always @(negedge clk) begin
        if (h6_a_rd_vld === 1'b1 || h6_b_rd_vld === 1'b1) begin
            n_tests = n_tests + 1;
            if (h6_a_rd_vld === 1'b1 && h6_b_rd_vld === 1'b1) begin
                n_fail = n_fail + 1;
                $display("FAIL rd_vld_both: got a=1 b=1, required at most one");
            end else if (sb.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL rd_vld_unexpected: got a=%0b b=%0b, required none", h6_a_rd_vld, h6_b_rd_vld);
            end else begin
                mon_e = sb.pop_front();
                if (h6_b_rd_vld !== mon_e.who || h6_rd_dt0 !== mon_e.d0 || h6_rd_dt1 !== mon_e.d1) begin
                    n_fail = n_fail + 1;
                    $display("FAIL rd_return: got who=%0b dt0=%h dt1=%h, required who=%0b dt0=%h dt1=%h",
                             h6_b_rd_vld, h6_rd_dt0, h6_rd_dt1, mon_e.who, mon_e.d0, mon_e.d1);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_a(input logic req, input logic typ, input logic sz, input logic lock,
                           input logic [DW-1:0] adrs, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        h5_a_req = req; h5_a_type = typ; h5_a_sz = sz; h5_a_lock = lock;
        h5_a_adrs = adrs; h5_a_wr_dt0 = d0; h5_a_wr_dt1 = d1;
    endtask

    task automatic drive_b(input logic req, input logic typ, input logic sz, input logic lock,
                           input logic [DW-1:0] adrs, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        h5_b_req = req; h5_b_type = typ; h5_b_sz = sz; h5_b_lock = lock;
        h5_b_adrs = adrs; h5_b_wr_dt0 = d0; h5_b_wr_dt1 = d1;
    endtask

    task automatic idle_all();
        drive_a(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive_b(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // Move to the drive point just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        rst = 1'b1;
    endtask

    // Let outstanding returns drain, then confirm nothing expected is left over.
    task automatic drain(input string name);
        idle_all();
        repeat (2) next_cycle();
        n_tests = n_tests + 1;
        if (sb.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL %s_drain: got %0d returns outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_all();
        rst = 1'b0;
        #2;
        n_tests = n_tests + 1;
        if ({h5_a_ack, h5_b_ack, h5_hmem_acs_en, h6_a_rd_vld, h6_b_rd_vld} !== 5'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_idle_ctrl: got %b, required 00000",
                     {h5_a_ack, h5_b_ack, h5_hmem_acs_en, h6_a_rd_vld, h6_b_rd_vld});
        end
        n_tests = n_tests + 1;
        if ({h5_hmem_acs_type, h5_hmem_acs_sz, h5_hmem_acs_adrs, h5_hmem_wr_dt0, h5_hmem_wr_dt1} !== '0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_idle_fields: got adrs=%h dt0=%h, required all 0", h5_hmem_acs_adrs, h5_hmem_wr_dt0);
        end
        // A alone during reset is granted by the idle rules.
        drive_a(1'b1, 1'b1, 1'b1, 1'b1, 32'h44, 32'h1111, 32'h2222);
        #1;
        n_tests = n_tests + 1;
        if ({h5_a_ack, h5_b_ack, h5_hmem_acs_en} !== 3'b101 || h5_hmem_acs_adrs !== 32'h44 ||
            h5_hmem_wr_dt0 !== 32'h1111 || h5_hmem_wr_dt1 !== 32'h2222) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_a_alone: got ack=%b%b adrs=%h dt0=%h, required ack=10 adrs=44 dt0=1111",
                     h5_a_ack, h5_b_ack, h5_hmem_acs_adrs, h5_hmem_wr_dt0);
        end
        // A tie during reset goes to A.
        drive_b(1'b1, 1'b0, 1'b0, 1'b0, 32'h55, '0, '0);
        #1;
        n_tests = n_tests + 1;
        if ({h5_a_ack, h5_b_ack} !== 2'b10) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_tie: got ack=%b%b, required 10", h5_a_ack, h5_b_ack);
        end
        // B alone reads during reset across an edge; no return is registered.
        drive_a(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        n_tests = n_tests + 1;
        if ({h5_a_ack, h5_b_ack} !== 2'b01 || h5_hmem_acs_adrs !== 32'h55 || h5_hmem_acs_type !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_b_alone: got ack=%b%b adrs=%h, required ack=01 adrs=55",
                     h5_a_ack, h5_b_ack, h5_hmem_acs_adrs);
        end
        next_cycle();
        n_tests = n_tests + 1;
        if ({h6_a_rd_vld, h6_b_rd_vld} !== 2'b00) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_hold_vld: got %b%b, required 00", h6_a_rd_vld, h6_b_rd_vld);
        end
        idle_all();
        next_cycle();
        rst = 1'b1;
        drain("reset");
    endtask

    task automatic test_single_read();
        do_reset();
        drive_a(1'b1, 1'b0, 1'b1, 1'b0, 32'h40, '0, '0);
        @(negedge clk);
        n_tests = n_tests + 1;
        if ({h5_a_ack, h5_b_ack, h5_hmem_acs_en, h5_hmem_acs_type, h5_hmem_acs_sz} !== 5'b10101 ||
            h5_hmem_acs_adrs !== 32'h40) begin
            n_fail = n_fail + 1;
            $display("FAIL single_grant: got ack=%b%b en=%b type=%b sz=%b adrs=%h, required 10 1 0 1 40",
                     h5_a_ack, h5_b_ack, h5_hmem_acs_en, h5_hmem_acs_type, h5_hmem_acs_sz, h5_hmem_acs_adrs);
        end
        sb.push_back('{who: 1'b0, d0: pat(32'h40), d1: pat(32'h41)});
        next_cycle();
        idle_all();
        @(negedge clk);
        n_tests = n_tests + 1;
        if ({h6_a_rd_vld, h6_b_rd_vld, h5_hmem_acs_en} !== 3'b100) begin
            n_fail = n_fail + 1;
            $display("FAIL single_vld: got a=%b b=%b en=%b, required 1 0 0", h6_a_rd_vld, h6_b_rd_vld, h5_hmem_acs_en);
        end
        drain("single");
    endtask

    task automatic test_round_robin();
        logic exp_a;
        do_reset();
        drive_a(1'b1, 1'b0, 1'b1, 1'b0, 32'h200, '0, '0);
        drive_b(1'b1, 1'b0, 1'b1, 1'b0, 32'h300, '0, '0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp_a = (i % 2 == 0);
            n_tests = n_tests + 1;
            if ({h5_a_ack, h5_b_ack} !== {exp_a, !exp_a} ||
                h5_hmem_acs_adrs !== (exp_a ? 32'h200 : 32'h300)) begin
                n_fail = n_fail + 1;
                $display("FAIL rr_grant[%0d]: got ack=%b%b adrs=%h, required ack=%b%b", i,
                         h5_a_ack, h5_b_ack, h5_hmem_acs_adrs, exp_a, !exp_a);
            end
            if (i > 0) begin
                n_tests = n_tests + 1;
                if ({h6_a_rd_vld, h6_b_rd_vld} !== {!exp_a, exp_a}) begin
                    n_fail = n_fail + 1;
                    $display("FAIL rr_vld[%0d]: got %b%b, required %b%b", i,
                             h6_a_rd_vld, h6_b_rd_vld, !exp_a, exp_a);
                end
            end
            if (exp_a) sb.push_back('{who: 1'b0, d0: pat(32'h200), d1: pat(32'h201)});
            else       sb.push_back('{who: 1'b1, d0: pat(32'h300), d1: pat(32'h301)});
            next_cycle();
        end
        drain("rr");
    endtask

    task automatic test_lock_release();
        logic exp_a;
        do_reset();
        drive_b(1'b1, 1'b0, 1'b1, 1'b0, 32'h300, '0, '0);
        for (int i = 0; i < 5; i++) begin
            drive_a(1'b1, 1'b1, 1'b0, (i < 3), 32'h80 + i, 32'ha000 + i, '0);
            @(negedge clk);
            exp_a = (i < 4);
            n_tests = n_tests + 1;
            if ({h5_a_ack, h5_b_ack} !== {exp_a, !exp_a}) begin
                n_fail = n_fail + 1;
                $display("FAIL lock_grant[%0d]: got ack=%b%b, required %b%b", i,
                         h5_a_ack, h5_b_ack, exp_a, !exp_a);
            end
            if (exp_a) begin
                n_tests = n_tests + 1;
                if (h5_hmem_acs_type !== 1'b1 || h5_hmem_wr_dt0 !== 32'ha000 + i) begin
                    n_fail = n_fail + 1;
                    $display("FAIL lock_wdata[%0d]: got type=%b dt0=%h, required 1 %h", i,
                             h5_hmem_acs_type, h5_hmem_wr_dt0, 32'ha000 + i);
                end
            end else begin
                sb.push_back('{who: 1'b1, d0: pat(32'h300), d1: pat(32'h301)});
            end
            next_cycle();
        end
        drain("lock");
    endtask

    task automatic test_starvation();
        logic exp_a;
        do_reset();
        drive_a(1'b1, 1'b1, 1'b0, 1'b1, 32'h90, 32'h9999, '0);
        drive_b(1'b1, 1'b0, 1'b1, 1'b0, 32'h310, '0, '0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            exp_a = (i != 10);
            n_tests = n_tests + 1;
            if ({h5_a_ack, h5_b_ack} !== {exp_a, !exp_a}) begin
                n_fail = n_fail + 1;
                $display("FAIL starve_grant[%0d]: got ack=%b%b, required %b%b", i,
                         h5_a_ack, h5_b_ack, exp_a, !exp_a);
            end
            if (!exp_a) sb.push_back('{who: 1'b1, d0: pat(32'h310), d1: pat(32'h311)});
            next_cycle();
        end
        drain("starve");
    endtask

    task automatic test_write_read_b();
        do_reset();
        drive_b(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'hdead, 32'hbeef);
        @(negedge clk);
        n_tests = n_tests + 1;
        if ({h5_b_ack, h5_hmem_acs_type, h5_hmem_acs_sz} !== 3'b111 || h5_hmem_acs_adrs !== 32'h100 ||
            h5_hmem_wr_dt0 !== 32'hdead || h5_hmem_wr_dt1 !== 32'hbeef) begin
            n_fail = n_fail + 1;
            $display("FAIL wr_b_fields: got ack=%b type=%b adrs=%h dt=%h/%h, required 1 1 100 dead/beef",
                     h5_b_ack, h5_hmem_acs_type, h5_hmem_acs_adrs, h5_hmem_wr_dt0, h5_hmem_wr_dt1);
        end
        next_cycle();
        drive_b(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, '0, '0);
        @(negedge clk);
        n_tests = n_tests + 1;
        if ({h5_b_ack, h5_hmem_acs_type, h6_a_rd_vld, h6_b_rd_vld} !== 4'b1000) begin
            n_fail = n_fail + 1;
            $display("FAIL rd_b_grant: got ack=%b type=%b vld=%b%b, required 1 0 00",
                     h5_b_ack, h5_hmem_acs_type, h6_a_rd_vld, h6_b_rd_vld);
        end
        sb.push_back('{who: 1'b1, d0: 32'hdead, d1: 32'hbeef});
        next_cycle();
        idle_all();
        @(negedge clk);
        n_tests = n_tests + 1;
        if ({h6_a_rd_vld, h6_b_rd_vld} !== 2'b01) begin
            n_fail = n_fail + 1;
            $display("FAIL rd_b_vld: got %b%b, required 01", h6_a_rd_vld, h6_b_rd_vld);
        end
        drain("wr_rd_b");
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        drive_b(1'b1, 1'b0, 1'b1, 1'b1, 32'h120, '0, '0);
        @(negedge clk);
        n_tests = n_tests + 1;
        if ({h5_a_ack, h5_b_ack} !== 2'b01) begin
            n_fail = n_fail + 1;
            $display("FAIL rml_enter: got ack=%b%b, required 01", h5_a_ack, h5_b_ack);
        end
        next_cycle();
        drive_a(1'b1, 1'b0, 1'b1, 1'b0, 32'h220, '0, '0);
        #1;
        n_tests = n_tests + 1;
        if ({h6_b_rd_vld, h5_a_ack, h5_b_ack} !== 3'b101) begin
            n_fail = n_fail + 1;
            $display("FAIL rml_locked: got vld_b=%b ack=%b%b, required 1 01", h6_b_rd_vld, h5_a_ack, h5_b_ack);
        end
        rst = 1'b0;
        #1;
        n_tests = n_tests + 1;
        if ({h6_a_rd_vld, h6_b_rd_vld, h5_a_ack, h5_b_ack} !== 4'b0010) begin
            n_fail = n_fail + 1;
            $display("FAIL rml_reset: got vld=%b%b ack=%b%b, required 00 10",
                     h6_a_rd_vld, h6_b_rd_vld, h5_a_ack, h5_b_ack);
        end
        idle_all();
        next_cycle();
        rst = 1'b1;
        drive_a(1'b1, 1'b0, 1'b1, 1'b0, 32'h220, '0, '0);
        drive_b(1'b1, 1'b0, 1'b1, 1'b0, 32'h320, '0, '0);
        @(negedge clk);
        n_tests = n_tests + 1;
        if ({h5_a_ack, h5_b_ack} !== 2'b10) begin
            n_fail = n_fail + 1;
            $display("FAIL rml_first_tie: got ack=%b%b, required 10", h5_a_ack, h5_b_ack);
        end
        sb.push_back('{who: 1'b0, d0: pat(32'h220), d1: pat(32'h221)});
        next_cycle();
        @(negedge clk);
        n_tests = n_tests + 1;
        if ({h5_a_ack, h5_b_ack} !== 2'b01) begin
            n_fail = n_fail + 1;
            $display("FAIL rml_second: got ack=%b%b, required 01", h5_a_ack, h5_b_ack);
        end
        sb.push_back('{who: 1'b1, d0: pat(32'h320), d1: pat(32'h321)});
        next_cycle();
        drain("rml");
    endtask

    // Watchdog: the sequence is fixed-length, so this only trips on a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        idle_all();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock_release();
        test_starvation();
        test_write_read_b();
        test_reset_mid_lock();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
